// File: rtl/rcl_sched_pkg.sv
// rcl_sched_pkg: state encoding, result codes and load constants shared by the
// rcl_sched scheduler and its round-robin arbiter.
package rcl_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } state_t;

    localparam logic [1:0] RES_DISJOINT  = 2'd0;
    localparam logic [1:0] RES_TANGENT   = 2'd1;
    localparam logic [1:0] RES_INTERSECT = 2'd2;
    localparam logic [1:0] RES_TIMEOUT   = 2'd3;

    localparam int CW_DEFAULT = 5;
    localparam int LOAD_BEATS = 3;

endpackage

// File: rtl/rcl_sched_rr_arb.sv
// rcl_rr_arb: combinational round-robin picker. Scans upward from the index
// after last_grant, wrapping, and reports the first requester found.
module rcl_rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant,
    output logic          any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant) + i) % N;
            if (!any_valid && req[IW'(idx)]) begin
                grant     = IW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rcl_sched.sv
// rcl_sched: shares one serial line/circle relation engine among NUM_REQ
// requesters. Optional result counters are enabled with RCL_SCHED_STATS_EN.
module rcl_sched
    import rcl_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = CW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*3*CW-1:0]    req_coef_l,
    input  logic [NUM_REQ*3*CW-1:0]    req_coef_q,
    output logic                       eng_in_valid,
    output logic [CW-1:0]              eng_coef_l,
    output logic [CW-1:0]              eng_coef_q,
    input  logic                       eng_out_valid,
    input  logic [1:0]                 eng_out,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [1:0]                 rsp_result,
    output logic                       busy
`ifdef RCL_SCHED_STATS_EN
    ,
    output logic [15:0]                stat_disjoint,
    output logic [15:0]                stat_tangent,
    output logic [15:0]                stat_intersect,
    output logic [15:0]                stat_timeout
`endif
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int SW  = 3 * CW;
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   cur_id;
    logic            any_valid;
    logic [1:0]      cnt;
    logic [WDW-1:0]  wd;
    logic [2*CW-1:0] l_rest;
    logic [2*CW-1:0] q_rest;
    logic [SW-1:0]   set_l;
    logic [SW-1:0]   set_q;

    rcl_rr_arb #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    assign set_l = req_coef_l[int'(grant)*SW +: SW];
    assign set_q = req_coef_q[int'(grant)*SW +: SW];

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && any_valid) begin
            req_ready[grant] = 1'b1;
        end
    end

    // The first beat is registered on the accept edge; the remaining beats
    // shift out of l_rest/q_rest, so LOAD lasts exactly LOAD_BEATS cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last_grant   <= IW'(NUM_REQ - 1);
            cur_id       <= '0;
            cnt          <= '0;
            wd           <= '0;
            l_rest       <= '0;
            q_rest       <= '0;
            eng_in_valid <= 1'b0;
            eng_coef_l   <= '0;
            eng_coef_q   <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        last_grant   <= grant;
                        cur_id       <= grant;
                        eng_in_valid <= 1'b1;
                        eng_coef_l   <= set_l[SW-1 -: CW];
                        eng_coef_q   <= set_q[SW-1 -: CW];
                        l_rest       <= set_l[2*CW-1:0];
                        q_rest       <= set_q[2*CW-1:0];
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cnt == 2'(LOAD_BEATS - 1)) begin
                        eng_in_valid <= 1'b0;
                        eng_coef_l   <= '0;
                        eng_coef_q   <= '0;
                        wd           <= '0;
                        state        <= ST_WAIT;
                    end else begin
                        eng_coef_l <= l_rest[2*CW-1 -: CW];
                        eng_coef_q <= q_rest[2*CW-1 -: CW];
                        l_rest     <= l_rest << CW;
                        q_rest     <= q_rest << CW;
                        cnt        <= cnt + 2'd1;
                    end
                end
                ST_WAIT: begin
                    // A genuine result wins over the watchdog in the same cycle.
                    if (eng_out_valid) begin
                        rsp_result <= eng_out;
                        rsp_id     <= cur_id;
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end else if (wd == WDW'(TIMEOUT - 1)) begin
                        rsp_result <= RES_TIMEOUT;
                        rsp_id     <= cur_id;
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_GAP;
                end
                ST_GAP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RCL_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_disjoint  <= '0;
            stat_tangent   <= '0;
            stat_intersect <= '0;
            stat_timeout   <= '0;
        end else if (rsp_valid) begin
            case (rsp_result)
                RES_DISJOINT:  if (stat_disjoint  != 16'hFFFF) stat_disjoint  <= stat_disjoint  + 16'd1;
                RES_TANGENT:   if (stat_tangent   != 16'hFFFF) stat_tangent   <= stat_tangent   + 16'd1;
                RES_INTERSECT: if (stat_intersect != 16'hFFFF) stat_intersect <= stat_intersect + 16'd1;
                default:       if (stat_timeout   != 16'hFFFF) stat_timeout   <= stat_timeout   + 16'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rcl_sched.sv
// tb_rcl_sched: directed and randomized checks of rcl_sched against a
// transaction-level model of arbitration, load beats and response timing.
module tb_rcl_sched;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = 5;
    localparam int IW      = $clog2(NUM_REQ);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*3*CW-1:0] req_coef_l;
    logic [NUM_REQ*3*CW-1:0] req_coef_q;
    logic                    eng_in_valid;
    logic [CW-1:0]           eng_coef_l;
    logic [CW-1:0]           eng_coef_q;
    logic                    eng_out_valid;
    logic [1:0]              eng_out;
    logic                    rsp_valid;
    logic [IW-1:0]           rsp_id;
    logic [1:0]              rsp_result;
    logic                    busy;
`ifdef RCL_SCHED_STATS_EN
    logic [15:0] stat_disjoint, stat_tangent, stat_intersect, stat_timeout;
`endif

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] cl [NUM_REQ][3];
    logic [CW-1:0] cq [NUM_REQ][3];
    int            rem [NUM_REQ];
    int            mdl_last;
    int            stat_exp [4];

    int         eng_lat_g = 0;
    logic [1:0] eng_res_g = 2'd0;
    logic       spur_req  = 1'b0;

    rcl_sched #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_coef_l    (req_coef_l),
        .req_coef_q    (req_coef_q),
        .eng_in_valid  (eng_in_valid),
        .eng_coef_l    (eng_coef_l),
        .eng_coef_q    (eng_coef_q),
        .eng_out_valid (eng_out_valid),
        .eng_out       (eng_out),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .busy          (busy)
`ifdef RCL_SCHED_STATS_EN
        ,
        .stat_disjoint  (stat_disjoint),
        .stat_tangent   (stat_tangent),
        .stat_intersect (stat_intersect),
        .stat_timeout   (stat_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Engine model: counts load beats, then answers eng_lat_g cycles after
    // the last beat (negative latency means it never answers).
    initial begin
        int beats;
        int cd;
        bit active;
        beats = 0;
        cd = 0;
        active = 1'b0;
        eng_out_valid = 1'b0;
        eng_out = 2'd0;
        forever begin
            @(negedge clk);
            eng_out_valid = 1'b0;
            eng_out = 2'($urandom_range(0, 3));
            if (active) begin
                if (cd == 0) begin
                    eng_out_valid = 1'b1;
                    eng_out = eng_res_g;
                    active = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (spur_req) begin
                eng_out_valid = 1'b1;
                eng_out = 2'd2;
                spur_req = 1'b0;
            end
            if (eng_in_valid) begin
                beats++;
                if (beats == 3 && eng_lat_g >= 0) begin
                    active = 1'b1;
                    cd = eng_lat_g;
                end
            end else begin
                beats = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pack_coefs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_coef_l[i*3*CW +: 3*CW] = {cl[i][0], cl[i][1], cl[i][2]};
            req_coef_q[i*3*CW +: 3*CW] = {cq[i][0], cq[i][1], cq[i][2]};
        end
    endtask

    task automatic apply_stimulus(input int id, input int count);
        for (int j = 0; j < 3; j++) begin
            cl[id][j] = CW'($urandom);
            cq[id][j] = CW'($urandom);
        end
        rem[id] = count;
        req_valid[id] = (count > 0);
        pack_coefs();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
        for (int i = 0; i < 4; i++) stat_exp[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mdl_last = NUM_REQ - 1;
    endtask

    // Next grant: lowest valid id above the last grant, else lowest valid id.
    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
        int best;
        best = -1;
        for (int i = NUM_REQ - 1; i > last; i--) if (v[i]) best = i;
        if (best < 0) for (int i = NUM_REQ - 1; i >= 0; i--) if (v[i]) best = i;
        return best;
    endfunction

    // One full transaction: grant, three beats, wait, response, gap.
    task automatic serve_one(input int lat, input int fixed_res);
        int exp_id, exp_idx, waited, pending_ok;
        logic [1:0] exp_res;
        logic [CW-1:0] bl [3];
        logic [CW-1:0] bq [3];
        bit got, quiet;
        pending_ok = (req_valid != 0);
        exp_id = model_pick(req_valid, mdl_last);
        eng_lat_g = lat;
        eng_res_g = (fixed_res >= 0) ? 2'(fixed_res) : 2'($urandom_range(0, 2));
        if (lat < 0 || lat > TIMEOUT - 1) begin
            exp_res = 2'd3;
            exp_idx = TIMEOUT;
        end else begin
            exp_res = eng_res_g;
            exp_idx = lat + 1;
        end
        waited = 0;
        @(negedge clk);
        while (req_ready == 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_output("grant_onehot", req_ready, (exp_id >= 0) ? (64'd1 << exp_id) : 64'd0);
        if (req_ready == 0 || exp_id < 0) return;
        if (pending_ok != 0) check_output("grant_latency", waited, 0);
        for (int j = 0; j < 3; j++) begin
            bl[j] = cl[exp_id][j];
            bq[j] = cq[exp_id][j];
        end
        @(posedge clk);
        #1;
        mdl_last = exp_id;
        if (rem[exp_id] > 0) rem[exp_id]--;
        apply_stimulus(exp_id, rem[exp_id]);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check_output("beat_valid", eng_in_valid, 1);
            check_output("beat_coef_l", eng_coef_l, bl[b]);
            check_output("beat_coef_q", eng_coef_q, bq[b]);
            check_output("load_busy_noready", {busy, req_ready}, {1'b1, NUM_REQ'(0)});
        end
        got = 1'b0;
        quiet = 1'b1;
        for (int w = 0; w < TIMEOUT + 20 && !got; w++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                waited = w;
            end else if (eng_in_valid || req_ready != 0 || !busy || eng_coef_l != 0 || eng_coef_q != 0) begin
                quiet = 1'b0;
            end
        end
        check_output("wait_quiet", quiet, 1);
        check_output("rsp_seen", got, 1);
        if (!got) return;
        check_output("rsp_time", waited, exp_idx);
        check_output("rsp_id", rsp_id, exp_id);
        check_output("rsp_result", rsp_result, exp_res);
        check_output("resp_no_load", {eng_in_valid, busy}, 2'b01);
        stat_exp[exp_res]++;
        @(negedge clk);
        check_output("gap_state", {rsp_valid, eng_in_valid, busy, req_ready}, {3'b001, NUM_REQ'(0)});
    endtask

    initial begin
        logic [CW-1:0] sv_l;
        int guard;
        req_valid = '0;
        req_coef_l = '0;
        req_coef_q = '0;
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 0);
        $display("[TB] reset values");
        reset_dut();
        check_output("reset_eng", {eng_in_valid, eng_coef_l, eng_coef_q}, '0);
        check_output("reset_rsp", {rsp_valid, rsp_id, rsp_result}, '0);
        check_output("reset_busy_ready", {busy, req_ready}, '0);

        $display("[TB] stray engine result while idle");
        spur_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("stray_ignored", {busy, rsp_valid, eng_in_valid}, 3'b000);

        $display("[TB] single request from requester 0");
        cl[0][0] = 5'd1; cl[0][1] = 5'd0; cl[0][2] = 5'd0;
        cq[0][0] = 5'd3; cq[0][1] = 5'd0; cq[0][2] = 5'd4;
        pack_coefs();
        rem[0] = 1;
        req_valid[0] = 1'b1;
        serve_one(2, 0);

        $display("[TB] all four requesters after reset");
        reset_dut();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 1);
        for (int i = 0; i < NUM_REQ; i++) serve_one($urandom_range(0, 10), -1);

        $display("[TB] requesters 1 and 3 alternate");
        apply_stimulus(1, 3);
        apply_stimulus(3, 3);
        for (int i = 0; i < 6; i++) serve_one($urandom_range(0, 6), -1);

        $display("[TB] hung engine then normal service");
        apply_stimulus(0, 1);
        apply_stimulus(2, 1);
        serve_one(-1, -1);
        serve_one(3, -1);

        $display("[TB] result and watchdog in the same cycle");
        apply_stimulus(1, 1);
        serve_one(TIMEOUT - 1, 1);
        apply_stimulus(2, 1);
        serve_one(TIMEOUT, 2);

        $display("[TB] reset during load");
        apply_stimulus(1, 1);
        @(negedge clk);
        check_output("pre_reset_grant", req_ready, 4'b0010);
        sv_l = cl[1][0];
        @(posedge clk);
        #1;
        apply_stimulus(0, 1);
        apply_stimulus(2, 1);
        @(negedge clk);
        check_output("pre_reset_beat0", {eng_in_valid, eng_coef_l}, {1'b1, sv_l});
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mdl_last = NUM_REQ - 1;
        #1;
        check_output("post_reset_quiet", {eng_in_valid, busy, rsp_valid}, 3'b000);
        check_output("post_reset_ready", req_ready, 4'b0001);
        for (int i = 0; i < 3; i++) serve_one($urandom_range(0, 8), -1);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, $urandom_range(0, 3));
            if (req_valid == 0) apply_stimulus(0, 1);
            guard = 0;
            while (req_valid != 0 && guard < 20) begin
                serve_one(($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 12), -1);
                guard++;
            end
        end

`ifdef RCL_SCHED_STATS_EN
        check_output("stat_disjoint", stat_disjoint, stat_exp[0]);
        check_output("stat_tangent", stat_tangent, stat_exp[1]);
        check_output("stat_intersect", stat_intersect, stat_exp[2]);
        check_output("stat_timeout", stat_timeout, stat_exp[3]);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
